fpu_cmd_issuer: RTL and testbench

//   Initiator side of the FPU command interface: buffers commands from a host over valid/ready.

---
 rtl/fpu_cmd_issuer.sv | 172 +++++++++++++++++
 tb/tb_fpu_cmd_issuer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmd_issuer.sv
// FPU command issuer: queues host commands, issues them one at a time to the FPU,
// and returns tagged results (or a qNaN timeout response) in issue order.
module fpu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_mode,
  input  logic [63:0] i_cmd_op1,
  input  logic [63:0] i_cmd_op2,
  input  logic [3:0]  i_cmd_tag,
  output logic        o_fpu_enable,
  output logic [2:0]  o_fpu_mode,
  output logic [63:0] o_fpu_operand_1,
  output logic [63:0] o_fpu_operand_2,
  input  logic [63:0] i_fpu_result,
  input  logic        i_fpu_done,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_result,
  output logic [3:0]  o_rsp_tag,
  output logic        o_rsp_timeout,
  output logic        o_busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [63:0]   QNAN    = 64'hFFF8_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]    r_mem_mode [DEPTH];
  logic [63:0]   r_mem_op1  [DEPTH];
  logic [63:0]   r_mem_op2  [DEPTH];
  logic [3:0]    r_mem_tag  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [2:0]    r_fpu_mode;
  logic [63:0]   r_fpu_op1;
  logic [63:0]   r_fpu_op2;
  logic [3:0]    r_iss_tag;
  logic [WW-1:0] r_wd;
  logic          r_rsp_valid;
  logic [63:0]   r_rsp_result;
  logic [3:0]    r_rsp_tag;
  logic          r_rsp_timeout;

  logic w_push;
  logic w_pop;

  // cmd_ready comes from the registered count only, so a full FIFO refuses even while popping
  assign o_cmd_ready = (r_count != FULL);
  assign w_push      = i_cmd_valid & o_cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (i_fpu_done || (r_wd == WD_LAST)) w_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_fpu_enable = (r_state == S_ISSUE);
    o_busy       = (r_state != S_IDLE) || (r_count != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_mode[r_wr_ptr] <= i_cmd_mode;
      r_mem_op1[r_wr_ptr]  <= i_cmd_op1;
      r_mem_op2[r_wr_ptr]  <= i_cmd_op2;
      r_mem_tag[r_wr_ptr]  <= i_cmd_tag;
    end
  end

  // The FPU-facing registers double as issue registers: loaded at pop, held until the next pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fpu_mode    <= '0;
      r_fpu_op1     <= '0;
      r_fpu_op2     <= '0;
      r_iss_tag     <= '0;
      r_wd          <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_tag     <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_fpu_mode <= r_mem_mode[r_rd_ptr];
            r_fpu_op1  <= r_mem_op1[r_rd_ptr];
            r_fpu_op2  <= r_mem_op2[r_rd_ptr];
            r_iss_tag  <= r_mem_tag[r_rd_ptr];
          end
        end
        S_ISSUE: r_wd <= '0;
        S_WAIT: begin
          r_wd <= r_wd + WW'(1);
          if (i_fpu_done) begin
            r_rsp_result  <= i_fpu_result;
            r_rsp_timeout <= 1'b0;
            r_rsp_tag     <= r_iss_tag;
            r_rsp_valid   <= 1'b1;
          end else if (r_wd == WD_LAST) begin
            r_rsp_result  <= QNAN;
            r_rsp_timeout <= 1'b1;
            r_rsp_tag     <= r_iss_tag;
            r_rsp_valid   <= 1'b1;
          end
        end
        S_RESP: if (i_rsp_ready) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_fpu_mode      = r_fpu_mode;
  assign o_fpu_operand_1 = r_fpu_op1;
  assign o_fpu_operand_2 = r_fpu_op2;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_result    = r_rsp_result;
  assign o_rsp_tag       = r_rsp_tag;
  assign o_rsp_timeout   = r_rsp_timeout;
endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Bench for fpu_cmd_issuer: table of single commands against a behavioural FPU,
// plus hand-written sequences for bursts, full FIFO, timeout, stall and reset.
module tb_fpu_cmd_issuer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam logic [63:0] QNAN = 64'hFFF8_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_mode;
  logic [63:0] cmd_op1;
  logic [63:0] cmd_op2;
  logic [3:0]  cmd_tag;
  logic        fpu_enable;
  logic [2:0]  fpu_mode;
  logic [63:0] fpu_operand_1;
  logic [63:0] fpu_operand_2;
  logic [63:0] fpu_result = '0;
  logic        fpu_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_timeout;
  logic        busy;

  always #5 clk = ~clk;

  fpu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_mode(cmd_mode),
    .i_cmd_op1(cmd_op1), .i_cmd_op2(cmd_op2), .i_cmd_tag(cmd_tag),
    .o_fpu_enable(fpu_enable), .o_fpu_mode(fpu_mode),
    .o_fpu_operand_1(fpu_operand_1), .o_fpu_operand_2(fpu_operand_2),
    .i_fpu_result(fpu_result), .i_fpu_done(fpu_done),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_result(rsp_result),
    .o_rsp_tag(rsp_tag), .o_rsp_timeout(rsp_timeout), .o_busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural FPU: real arithmetic for add/sub/mul/div, xor for the rest.
  function automatic logic [63:0] fpu_model(input logic [2:0] mode, input logic [63:0] a, input logic [63:0] b);
    real ra, rb;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    case (mode)
      3'd0:    return $realtobits(ra + rb);
      3'd1:    return $realtobits(ra - rb);
      3'd2:    return $realtobits(ra * rb);
      3'd3:    return $realtobits(ra / rb);
      default: return a ^ b;
    endcase
  endfunction

  int          m_lat = 0;
  int          m_cnt = 0;
  bit          m_active = 1'b0;
  logic [63:0] m_a, m_b, m_res;
  logic [2:0]  m_mode;
  int          m_en_count = 0;
  int          m_stab_err = 0;
  int          m_en_cyc[$];

  // m_lat == 0 models an FPU that never completes
  always @(negedge clk) begin
    fpu_done = 1'b0;
    if (rst) begin
      m_cnt    = 0;
      m_active = 1'b0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          fpu_done   = 1'b1;
          fpu_result = m_res;
        end
      end
      if (m_active) begin
        if (fpu_mode !== m_mode || fpu_operand_1 !== m_a || fpu_operand_2 !== m_b) m_stab_err++;
        if (rsp_valid) m_active = 1'b0;
      end
      if (fpu_enable) begin
        m_en_count++;
        m_en_cyc.push_back(cyc);
        m_mode   = fpu_mode;
        m_a      = fpu_operand_1;
        m_b      = fpu_operand_2;
        m_res    = fpu_model(fpu_mode, fpu_operand_1, fpu_operand_2);
        m_cnt    = m_lat;
        m_active = 1'b1;
      end
    end
  end

  typedef struct {
    logic [63:0] res;
    logic [3:0]  tag;
    logic        to;
  } rsp_t;
  rsp_t q_rsp[$];
  int   rv_cycles = 0;

  always @(negedge clk) begin
    if (rsp_valid) rv_cycles++;
    if (rsp_valid && rsp_ready) q_rsp.push_back(rsp_t'{rsp_result, rsp_tag, rsp_timeout});
  end

  typedef struct {
    logic [2:0]  mode;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  tag;
    int          lat;
    logic [63:0] exp_res;
    logic        exp_to;
  } vec_t;
  vec_t vecs[7];

  task automatic push_cmd(input logic [2:0] mode, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] tag);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_op1   = a;
    cmd_op2   = b;
    cmd_tag   = tag;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic wait_rsp_count(input string name, input int n, input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      if (q_rsp.size() >= n) break;
      tick();
    end
    check(name, q_rsp.size(), n);
  endtask

  task automatic wait_rsp_valid(input string name, input int max_cyc, output int at_cyc);
    bit ok = 1'b0;
    at_cyc = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok     = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    int en0, rv_cyc, en_at, unstable, leak, rv0;
    bit ok;
    logic [63:0] s_res;
    logic [3:0]  s_tag;
    logic        s_to;

    vecs[0] = '{3'd0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd5,  6, 64'h4008_0000_0000_0000, 1'b0};
    vecs[1] = '{3'd1, 64'h4014_0000_0000_0000, 64'h3FF8_0000_0000_0000, 4'd1,  2, 64'h400C_0000_0000_0000, 1'b0};
    vecs[2] = '{3'd2, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 4'd10, 1, 64'h4018_0000_0000_0000, 1'b0};
    vecs[3] = '{3'd3, 64'h3FF0_0000_0000_0000, 64'h4010_0000_0000_0000, 4'd15, 4, 64'h3FD0_0000_0000_0000, 1'b0};
    vecs[4] = '{3'd6, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 4'd3,  8, 64'hFEDC_4567_7654_CDEF, 1'b0};
    vecs[5] = '{3'd7, 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 4'd12, 0, QNAN,                   1'b1};
    vecs[6] = '{3'd5, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 4'd0,  7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_op1 = '0; cmd_op2 = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_fpu_enable", fpu_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_fpu_mode", fpu_mode, 0);
    check("rst_fpu_op1", fpu_operand_1, 0);
    check("rst_fpu_op2", fpu_operand_2, 0);
    rst = 1'b0;
    tick();

    rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      q_rsp.delete();
      en0   = m_en_count;
      m_lat = vecs[i].lat;
      push_cmd(vecs[i].mode, vecs[i].op1, vecs[i].op2, vecs[i].tag);
      wait_rsp_count($sformatf("vec%0d_rsp_count", i), 1, 60);
      if (q_rsp.size() > 0) begin
        check($sformatf("vec%0d_result", i), q_rsp[0].res, vecs[i].exp_res);
        check($sformatf("vec%0d_tag", i), q_rsp[0].tag, vecs[i].tag);
        check($sformatf("vec%0d_timeout", i), q_rsp[0].to, vecs[i].exp_to);
      end
      repeat (3) tick();
      check($sformatf("vec%0d_one_enable", i), m_en_count - en0, 1);
      check($sformatf("vec%0d_idle", i), busy, 0);
    end

    // Burst of five: the fifth fills the FIFO behind the in-flight first command
    q_rsp.delete();
    m_en_cyc.delete();
    en0   = m_en_count;
    m_lat = 3;
    for (int t = 0; t < 5; t++)
      push_cmd(3'd6, {t[3:0], 60'h0}, 64'h0000_0000_0000_00A5, t[3:0]);
    check("full_cmd_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_mode  = 3'd6;
    cmd_op1   = {4'hF, 60'h0};
    cmd_op2   = 64'h0000_0000_0000_00A5;
    cmd_tag   = 4'd15;
    ok   = 1'b0;
    leak = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fpu_enable) begin
        ok = 1'b1;
        break;
      end
      if (cmd_ready) leak++;
    end
    check("full_ready_low_through_pop", leak, 0);
    check("full_next_enable_seen", ok, 1);
    check("full_ready_after_pop", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    wait_rsp_count("burst_rsp_count", 6, 200);
    for (int i = 0; i < 6 && i < q_rsp.size(); i++) begin
      logic [3:0] et;
      et = (i == 5) ? 4'd15 : 4'(i);
      check($sformatf("burst_tag%0d", i), q_rsp[i].tag, et);
      check($sformatf("burst_res%0d", i), q_rsp[i].res, {et, 52'h0, 8'hA5});
    end
    check("burst_enables", m_en_count - en0, 6);
    for (int i = 1; i < m_en_cyc.size(); i++)
      check($sformatf("burst_enable_spacing%0d", i), m_en_cyc[i] - m_en_cyc[i-1], 3 + 4);
    repeat (3) tick();

    // Watchdog expiry with a late done arriving while the response is stalled
    q_rsp.delete();
    m_en_cyc.delete();
    m_lat     = 12;
    rsp_ready = 1'b0;
    push_cmd(3'd4, 64'h3FF0_0000_0000_0000, 64'h0, 4'd7);
    wait_rsp_valid("to_rsp_valid_seen", 40, rv_cyc);
    en_at = (m_en_cyc.size() > 0) ? m_en_cyc[0] : 0;
    check("to_wait_cycles", rv_cyc - en_at - 1, TIMEOUT);
    check("to_result", rsp_result, QNAN);
    check("to_flag", rsp_timeout, 1);
    check("to_tag", rsp_tag, 7);
    for (int k = 0; k < 40 && cyc < en_at + 15; k++) tick();
    check("late_done_valid_held", rsp_valid, 1);
    check("late_done_result_held", rsp_result, QNAN);
    check("late_done_flag_held", rsp_timeout, 1);
    rsp_ready = 1'b1;
    wait_rsp_count("to_rsp_count", 1, 20);
    repeat (20) tick();
    check("to_single_rsp", q_rsp.size(), 1);

    // Response stall with a second command queued
    q_rsp.delete();
    en0       = m_en_count;
    m_lat     = 3;
    rsp_ready = 1'b0;
    push_cmd(3'd2, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 4'd8);
    push_cmd(3'd3, 64'h3FF0_0000_0000_0000, 64'h4010_0000_0000_0000, 4'd9);
    wait_rsp_valid("stall_rsp_valid_seen", 40, rv_cyc);
    s_res = rsp_result;
    s_tag = rsp_tag;
    s_to  = rsp_timeout;
    check("stall_first_result", s_res, 64'h4018_0000_0000_0000);
    check("stall_first_tag", s_tag, 8);
    unstable = 0;
    repeat (20) begin
      tick();
      if (!rsp_valid || rsp_result !== s_res || rsp_tag !== s_tag || rsp_timeout !== s_to) unstable++;
    end
    check("stall_rsp_stable", unstable, 0);
    check("stall_no_second_enable", m_en_count - en0, 1);
    check("stall_busy", busy, 1);
    rsp_ready = 1'b1;
    wait_rsp_count("stall_rsp_count", 2, 60);
    if (q_rsp.size() > 1) begin
      check("stall_second_tag", q_rsp[1].tag, 9);
      check("stall_second_result", q_rsp[1].res, 64'h3FD0_0000_0000_0000);
    end
    check("stall_enables", m_en_count - en0, 2);
    repeat (3) tick();

    // Reset while waiting on the FPU, with one more command still queued
    q_rsp.delete();
    en0   = m_en_count;
    m_lat = 0;
    push_cmd(3'd0, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'd6);
    push_cmd(3'd1, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'd11);
    for (int k = 0; k < 20 && m_en_count == en0; k++) tick();
    repeat (3) tick();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_fpu_enable", fpu_enable, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    rv0 = rv_cycles;
    repeat (25) tick();
    check("post_rst_no_rsp", rv_cycles - rv0, 0);
    check("post_rst_no_enable", m_en_count - en0, 1);
    check("post_rst_idle", busy, 0);

    check("operands_stable", m_stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
